// File: rtl/tx_frame_arbiter.sv
// Round-robin arbiter that frames samples from two producers onto one AXI-stream UART byte channel.
// Frame: SYNC, header {4'hC,3'b000,ch}, sample bytes MSB first, XOR checksum of header and data.
module tx_frame_arbiter #(
  parameter int          TX_DATA_SIZE = 8,
  parameter int          SAMPLE_BYTES = 2,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_req_0,
  input  logic [SAMPLE_BYTES*8-1:0] i_sample_0,
  output logic                      o_ack_0,
  input  logic                      i_req_1,
  input  logic [SAMPLE_BYTES*8-1:0] i_sample_1,
  output logic                      o_ack_1,
  output logic [TX_DATA_SIZE-1:0]   o_tx_tdata,
  output logic                      o_tx_tvalid,
  input  logic                      i_tx_tready,
  output logic                      o_busy,
  output logic                      o_frame_done,
  output logic                      o_last_grant
);

  localparam int FRAME_LEN = SAMPLE_BYTES + 3;
  localparam int IDX_W     = $clog2(FRAME_LEN);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  logic [0:0]                state_reg;
  logic [IDX_W-1:0]          idx_reg;
  logic                      ch_reg;
  logic [SAMPLE_BYTES*8-1:0] sample_reg;
  logic [7:0]                csum_reg;
  logic [7:0]                tdata_reg;
  logic                      tvalid_reg;
  logic                      ack_0_reg;
  logic                      ack_1_reg;
  logic                      busy_reg;
  logic                      done_reg;
  logic                      last_grant_reg;

  logic                      grant_ch;
  logic [SAMPLE_BYTES*8-1:0] grant_sample;
  logic [7:0]                grant_csum;
  logic [IDX_W-1:0]          idx_next;
  logic [7:0]                byte_next;
  logic [7:0]                in_bytes  [SAMPLE_BYTES];
  logic [7:0]                cap_bytes [SAMPLE_BYTES];

  // Byte k of a sample is the k-th byte on the wire, so index 0 is the MSB byte.
  for (genvar gi = 0; gi < SAMPLE_BYTES; gi++) begin : g_bytes
    assign in_bytes[gi]  = grant_sample[(SAMPLE_BYTES-1-gi)*8 +: 8];
    assign cap_bytes[gi] = sample_reg[(SAMPLE_BYTES-1-gi)*8 +: 8];
  end

  always_comb begin
    grant_ch = ~last_grant_reg;
    if (i_req_0 && !i_req_1) grant_ch = 1'b0;
    else if (i_req_1 && !i_req_0) grant_ch = 1'b1;
    grant_sample = grant_ch ? i_sample_1 : i_sample_0;
    grant_csum   = {4'hC, 3'b000, grant_ch};
    for (int k = 0; k < SAMPLE_BYTES; k++) grant_csum = grant_csum ^ in_bytes[k];
  end

  // Byte to present after the current one is accepted; the checksum is the fall-through case.
  always_comb begin
    idx_next  = idx_reg + 1'b1;
    byte_next = csum_reg;
    if (idx_next == IDX_W'(1)) byte_next = {4'hC, 3'b000, ch_reg};
    for (int k = 0; k < SAMPLE_BYTES; k++) begin
      if (idx_next == IDX_W'(k + 2)) byte_next = cap_bytes[k];
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_reg      <= ST_IDLE;
      idx_reg        <= '0;
      ch_reg         <= 1'b0;
      sample_reg     <= '0;
      csum_reg       <= '0;
      tdata_reg      <= '0;
      tvalid_reg     <= 1'b0;
      ack_0_reg      <= 1'b0;
      ack_1_reg      <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      last_grant_reg <= 1'b1;
    end else begin
      ack_0_reg <= 1'b0;
      ack_1_reg <= 1'b0;
      done_reg  <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (i_req_0 || i_req_1) begin
            state_reg      <= ST_SEND;
            idx_reg        <= '0;
            ch_reg         <= grant_ch;
            sample_reg     <= grant_sample;
            csum_reg       <= grant_csum;
            ack_0_reg      <= ~grant_ch;
            ack_1_reg      <= grant_ch;
            last_grant_reg <= grant_ch;
            tvalid_reg     <= 1'b1;
            tdata_reg      <= SYNC_BYTE;
            busy_reg       <= 1'b1;
          end
        end
        ST_SEND: begin
          // tvalid is always high here, so tready alone marks a handshake.
          if (i_tx_tready) begin
            if (idx_reg == IDX_W'(FRAME_LEN - 1)) begin
              state_reg  <= ST_IDLE;
              idx_reg    <= '0;
              tvalid_reg <= 1'b0;
              busy_reg   <= 1'b0;
              done_reg   <= 1'b1;
            end else begin
              idx_reg   <= idx_next;
              tdata_reg <= byte_next;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign o_ack_0      = ack_0_reg;
  assign o_ack_1      = ack_1_reg;
  assign o_tx_tdata   = tdata_reg;
  assign o_tx_tvalid  = tvalid_reg;
  assign o_busy       = busy_reg;
  assign o_frame_done = done_reg;
  assign o_last_grant = last_grant_reg;

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Directed bench for tx_frame_arbiter: a 2-byte-sample instance and a 1-byte-sample instance.
module tb_tx_frame_arbiter;

  logic        clk = 1'b0;
  logic        srst;
  logic        tready;

  logic        req_0_a, req_1_a, ack_0_a, ack_1_a;
  logic [15:0] sample_0_a, sample_1_a;
  logic [7:0]  tdata_a;
  logic        tvalid_a, busy_a, done_a, last_a;

  logic        req_0_b, req_1_b, ack_0_b, ack_1_b;
  logic [7:0]  sample_0_b, sample_1_b;
  logic [7:0]  tdata_b;
  logic        tvalid_b, busy_b, done_b, last_b;

  logic        sel_b;
  logic [7:0]  m_tdata;
  logic        m_tvalid, m_ack_0, m_ack_1, m_busy, m_done;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tx_frame_arbiter #(.SAMPLE_BYTES(2)) dut_a (
    .i_clock(clk), .i_reset(srst),
    .i_req_0(req_0_a), .i_sample_0(sample_0_a), .o_ack_0(ack_0_a),
    .i_req_1(req_1_a), .i_sample_1(sample_1_a), .o_ack_1(ack_1_a),
    .o_tx_tdata(tdata_a), .o_tx_tvalid(tvalid_a), .i_tx_tready(tready),
    .o_busy(busy_a), .o_frame_done(done_a), .o_last_grant(last_a)
  );

  tx_frame_arbiter #(.SAMPLE_BYTES(1)) dut_b (
    .i_clock(clk), .i_reset(srst),
    .i_req_0(req_0_b), .i_sample_0(sample_0_b), .o_ack_0(ack_0_b),
    .i_req_1(req_1_b), .i_sample_1(sample_1_b), .o_ack_1(ack_1_b),
    .o_tx_tdata(tdata_b), .o_tx_tvalid(tvalid_b), .i_tx_tready(tready),
    .o_busy(busy_b), .o_frame_done(done_b), .o_last_grant(last_b)
  );

  assign m_tdata  = sel_b ? tdata_b  : tdata_a;
  assign m_tvalid = sel_b ? tvalid_b : tvalid_a;
  assign m_ack_0  = sel_b ? ack_0_b  : ack_0_a;
  assign m_ack_1  = sel_b ? ack_1_b  : ack_1_a;
  assign m_busy   = sel_b ? busy_b   : busy_a;
  assign m_done   = sel_b ? done_b   : done_a;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts in the cycle where SYNC is first presented; ends in the frame_done cycle.
  task automatic collect_frame(input string name, input logic [63:0] exp, input int len,
                               input int stall);
    int         n = 0;
    int         cyc = 0;
    logic       stalled = 1'b0;
    logic [7:0] prev = 8'h00;
    while (n < len && cyc < 200) begin
      tready = ((cyc % (stall + 1)) == 0);
      if (stalled) check({name, "_stall_hold"}, m_tdata, prev);
      check({name, "_tvalid_hold"}, m_tvalid, 1);
      check({name, "_busy"}, m_busy, 1);
      if (cyc > 0) check({name, "_no_ack"}, m_ack_0 | m_ack_1, 0);
      if (tready && m_tvalid) begin
        check({name, "_byte"}, m_tdata, exp[(len-1-n)*8 +: 8]);
        $display("%s byte %0d = 0x%02h", name, n, m_tdata);
        n++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        prev    = m_tdata;
      end
      tick();
      cyc++;
    end
    if (n < len) check({name, "_timeout"}, n, len);
    check({name, "_tvalid_end"}, m_tvalid, 0);
    check({name, "_frame_done"}, m_done, 1);
    check({name, "_busy_end"}, m_busy, 0);
    tready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    srst = 1'b1; tready = 1'b1; sel_b = 1'b0;
    req_0_a = 0; req_1_a = 0; sample_0_a = 16'h1234; sample_1_a = 16'hABCD;
    req_0_b = 0; req_1_b = 0; sample_0_b = 8'h5A;    sample_1_b = 8'h00;
    repeat (3) tick();
    srst = 1'b0;
    tick();

    // Reset values
    check("rst_ack_0", ack_0_a, 0);
    check("rst_ack_1", ack_1_a, 0);
    check("rst_tvalid", tvalid_a, 0);
    check("rst_tdata", tdata_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_last_grant", last_a, 1);
    $display("reset: tvalid=%0b busy=%0b last_grant=%0b", tvalid_a, busy_a, last_a);

    // Channel 0 alone, tready held high
    req_0_a = 1; tick();
    check("ch0_ack_0", ack_0_a, 1);
    check("ch0_ack_1", ack_1_a, 0);
    check("ch0_sync_same_cycle", tdata_a, 8'hA5);
    check("ch0_last_grant", last_a, 0);
    req_0_a = 0;
    collect_frame("ch0", 64'hA5C01234E6, 5, 0);
    tick();
    check("ch0_done_pulse", done_a, 0);

    // Channel 1 alone, tready 1 on / 3 off
    req_1_a = 1; tick();
    check("ch1_ack_1", ack_1_a, 1);
    check("ch1_ack_0", ack_0_a, 0);
    check("ch1_last_grant", last_a, 1);
    req_1_a = 0;
    collect_frame("ch1", 64'hA5C1ABCDA7, 5, 3);
    tick();

    // Both requests held: strict alternation with one idle bubble
    req_0_a = 1; req_1_a = 1; tick();
    for (int f = 0; f < 4; f++) begin
      check("alt_ack_0", ack_0_a, ((f % 2) == 0) ? 1 : 0);
      check("alt_ack_1", ack_1_a, ((f % 2) == 1) ? 1 : 0);
      check("alt_last_grant", last_a, f % 2);
      $display("alt frame %0d: ack_0=%0b ack_1=%0b", f, ack_0_a, ack_1_a);
      if ((f % 2) == 0) collect_frame("alt0", 64'hA5C01234E6, 5, 0);
      else              collect_frame("alt1", 64'hA5C1ABCDA7, 5, 0);
      if (f == 3) begin req_0_a = 0; req_1_a = 0; end
      tick();
    end
    check("alt_idle_ack", ack_0_a | ack_1_a, 0);
    tick();

    // Channel 1 raised during channel 0's frame waits for the next IDLE
    req_0_a = 1; tick();
    check("late_ack_0", ack_0_a, 1);
    req_0_a = 0; req_1_a = 1;
    collect_frame("late0", 64'hA5C01234E6, 5, 0);
    tick();
    check("late_ack_1", ack_1_a, 1);
    check("late_last_grant", last_a, 1);
    req_1_a = 0;
    collect_frame("late1", 64'hA5C1ABCDA7, 5, 0);
    tick();

    // Reset in the middle of a frame
    req_0_a = 1; tick();
    req_0_a = 0; tick(); tick();
    check("abort_midframe_tvalid", tvalid_a, 1);
    srst = 1'b1; tick();
    srst = 1'b0;
    check("abort_tvalid", tvalid_a, 0);
    check("abort_busy", busy_a, 0);
    check("abort_done", done_a, 0);
    check("abort_last_grant", last_a, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("abort_quiet_tvalid", tvalid_a, 0);
      check("abort_quiet_done", done_a, 0);
    end
    req_0_a = 1; tick();
    check("restart_ack_0", ack_0_a, 1);
    req_0_a = 0;
    collect_frame("restart", 64'hA5C01234E6, 5, 0);
    tick();

    // One-byte sample instance
    sel_b = 1'b1;
    req_0_b = 1; tick();
    check("sb1_ack_0", ack_0_b, 1);
    check("sb1_last_grant", last_b, 0);
    req_0_b = 0;
    collect_frame("sb1", 64'hA5C05A9A, 4, 0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tx_frame_arbiter.md
Name: tx_frame_arbiter

Overview:
- Shares one AXI-stream UART transmitter (`uart_tx` s_axis_* interface) between two sample producers.
- Round-robin arbitration between the two channels.
- Each granted sample is captured and sent as a framed byte sequence: SYNC, header (channel ID), data bytes MSB first, XOR checksum.
- Sits between the acquisition logic and a single `uart_tx`, so both channels share one serial line.

Parameters:
- TX_DATA_SIZE, 8, UART byte width; fixed at 8, other values unsupported.
- SAMPLE_BYTES, 2, data bytes per sample (1..8).
- SYNC_BYTE, 8'hA5, first byte of every frame.

Ports:
- i_clock  in  1  system clock
- i_reset  in  1  synchronous reset, active-high
- i_req_0  in  1  channel 0 request; held high with i_sample_0 stable until o_ack_0
- i_sample_0  in  SAMPLE_BYTES*8  channel 0 sample
- o_ack_0  out  1  one-cycle pulse; channel 0 sample captured
- i_req_1  in  1  channel 1 request
- i_sample_1  in  SAMPLE_BYTES*8  channel 1 sample
- o_ack_1  out  1  one-cycle pulse; channel 1 sample captured
- o_tx_tdata  out  TX_DATA_SIZE  byte to `uart_tx` s_axis_tdata
- o_tx_tvalid  out  1  to `uart_tx` s_axis_tvalid
- i_tx_tready  in  1  from `uart_tx` s_axis_tready
- o_busy  out  1  high while a frame is in progress (state SEND)
- o_frame_done  out  1  one-cycle pulse after the last byte of a frame is accepted
- o_last_grant  out  1  channel ID of the most recent grant

Behaviour:
- Reset (sync, applied at the edge): state=IDLE, byte index=0.
- Outputs at reset: o_ack_0/1=0, o_tx_tvalid=0, o_tx_tdata=0, o_busy=0, o_frame_done=0, o_last_grant=1 (so channel 0 wins the first tie).
- Reset mid-frame aborts the frame: no further bytes are sent, no ack is issued, and the captured sample is discarded.
- Frame format, length L = SAMPLE_BYTES+3:
  - byte 0 = SYNC_BYTE
  - byte 1 = header {4'hC, 3'b000, ch}
  - bytes 2..L-2 = sample, MSB byte first
  - byte L-1 = checksum = XOR of the header and all data bytes (SYNC excluded)
- All outputs are registered.
- State IDLE:
  - If any request is high, grant and, at the next edge:
    - capture the sample plus the precomputed checksum,
    - pulse o_ack_<ch> for 1 cycle,
    - set o_last_grant=ch,
    - set o_tx_tvalid=1 with tdata=SYNC_BYTE,
    - go to SEND with index 0.
  - Arbitration: if only one request is high, that channel wins. If both are high, the channel != o_last_grant wins (strict alternation under contention).
- State SEND:
  - o_tx_tvalid=1, o_busy=1.
  - tdata is held stable while tvalid && !tready (AXI rule: no tvalid withdrawal, no data change).
  - On tvalid && tready: index++ and tdata takes the next byte at the same edge.
  - If the accepted byte was index L-1: o_tx_tvalid=0, o_frame_done=1 for 1 cycle, go to IDLE.
- Requests are ignored while in SEND; no ack is issued until the next IDLE.
- Requester protocol: drop req on the cycle following the ack. A req still high in the next IDLE cycle is a new request.
- Throughput with tready held high:
  - L consecutive tvalid cycles, then 1 IDLE bubble, then the next frame's SYNC.
  - Minimum frame period L+1 cycles.
  - Ack-to-first-byte latency 0: the ack and the SYNC byte appear in the same cycle.
- Checksum width is 8 bits; XOR has no carry or overflow.
- o_ack_0 and o_ack_1 are never high in the same cycle.

Test Plan:
- Reset then idle: all outputs at reset values, o_last_grant=1. Assert reset for 1 cycle mid-SEND → tvalid=0 at the next edge, no frame_done, next frame restarts at SYNC.
- Ch0 alone, i_sample_0=16'h1234, tready=1 → o_ack_0 pulse; tdata sequence A5, C0, 12, 34, E6 on 5 consecutive cycles; frame_done 1 cycle after E6 is accepted; o_last_grant=0.
- Ch1 alone, i_sample_1=16'hABCD, tready toggling 1 cycle on / 3 off → sequence A5, C1, AB, CD, A7. tdata is stable and tvalid stays high through every stall; exactly 5 handshakes.
- Both reqs held permanently, sample0=0x1234, sample1=0xABCD → frames alternate ch0, ch1, ch0, ch1 (headers C0, C1, C0, C1); one idle bubble between frames; acks alternate.
- Ch1 req raised while ch0 frame in SEND → no o_ack_1 until ch0's frame_done; ch1 is granted in the following IDLE cycle.
- SAMPLE_BYTES=1, sample 8'h5A on ch0 → A5, C0, 5A, 9A.
